// File: rtl/camera_frame_reader_if.sv
// Signal bundle of the camera frame reader: custom-instruction port, burst-read bus and pixel stream.
// The master modport is the reader's view; slave is the environment's.
interface camera_frame_reader_if;
  logic        ciStart;
  logic        ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic [31:0] ciResult;
  logic        ciDone;

  logic        requestBus;
  logic        busGrant;
  logic        beginTransactionOut;
  logic        endTransactionOut;
  logic [31:0] addressDataOut;
  logic        readNotWriteOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic [31:0] addressDataIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busErrorIn;

  logic [15:0] pixelData;
  logic        pixelValid;
  logic        pixelReady;
  logic        frameEnd;

  modport master (
    input  ciStart, ciCke, ciN, ciValueA, ciValueB,
    output ciResult, ciDone,
    output requestBus, beginTransactionOut, endTransactionOut, addressDataOut,
    output readNotWriteOut, byteEnablesOut, burstSizeOut,
    input  busGrant, addressDataIn, dataValidIn, endTransactionIn, busErrorIn,
    output pixelData, pixelValid, frameEnd,
    input  pixelReady
  );

  modport slave (
    output ciStart, ciCke, ciN, ciValueA, ciValueB,
    input  ciResult, ciDone,
    input  requestBus, beginTransactionOut, endTransactionOut, addressDataOut,
    input  readNotWriteOut, byteEnablesOut, burstSizeOut,
    output busGrant, addressDataIn, dataValidIn, endTransactionIn, busErrorIn,
    input  pixelData, pixelValid, frameEnd,
    output pixelReady
  );
endinterface

// File: rtl/camera_frame_reader.sv
// Burst-reads an RGB565 frame (two pixels per word) into a small FIFO and streams it out pixel by pixel.
// Configured and started through a custom instruction; a burst is only requested when it fits entirely.
module camera_frame_reader #(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int         fifoDepthLog2       = 4
) (
  input logic                  clock,
  input logic                  reset,
  camera_frame_reader_if.master bus
);

  localparam int Depth = 1 << fifoDepthLog2;
  localparam int AW    = fifoDepthLog2;
  localparam int CW    = fifoDepthLog2 + 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQUEST = 3'd1;
  localparam logic [2:0] INIT    = 3'd2;
  localparam logic [2:0] READ    = 3'd3;
  localparam logic [2:0] WAIT    = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ABORT   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [31:0]   curAddr_q, curAddr_d;
  logic [18:0]   wordCount_q, wordCount_d;
  logic [18:0]   remaining_q, remaining_d;
  logic [18:0]   outWords_q, outWords_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          halfSel_q, halfSel_d;
  logic [31:0]   mem_q [Depth];

  logic          ciSel;
  logic [2:0]    ciOp;
  logic          busy;
  logic [CW-1:0] freeSlots;
  logic          push;
  logic          pixelXfer;
  logic          pop;
  logic [31:0]   headWord;
  logic          unusedCi;

  function automatic logic [CW-1:0] burstOf(input logic [18:0] words);
    return (words >= 19'(Depth)) ? CW'(Depth) : CW'(words);
  endfunction

  assign ciSel     = bus.ciStart & bus.ciCke & (bus.ciN == customInstructionId);
  assign ciOp      = bus.ciValueA[2:0];
  assign unusedCi  = ^bus.ciValueA[31:3];
  assign busy      = (state_q != IDLE);
  assign freeSlots = CW'(Depth) - count_q;
  assign push      = (state_q == READ) & bus.dataValidIn;
  assign pixelXfer = bus.pixelValid & bus.pixelReady;
  assign pop       = pixelXfer & halfSel_q;
  assign headWord  = mem_q[rdPtr_q];

  // Custom-instruction read path is purely combinational.
  always_comb begin
    bus.ciResult = 32'd0;
    if (ciSel) begin
      case (ciOp)
        3'd3:    bus.ciResult = {29'd0, error_q, done_q, busy};
        3'd4:    bus.ciResult = base_q;
        default: bus.ciResult = 32'd0;
      endcase
    end
  end
  assign bus.ciDone = ciSel;

  assign bus.requestBus          = (state_q == REQUEST);
  assign bus.beginTransactionOut = (state_q == INIT);
  assign bus.endTransactionOut   = (state_q == ABORT);
  assign bus.readNotWriteOut     = (state_q == INIT);
  assign bus.addressDataOut      = (state_q == INIT) ? curAddr_q : 32'd0;
  assign bus.byteEnablesOut      = (state_q == INIT) ? 4'hF : 4'h0;
  assign bus.burstSizeOut        = (state_q == INIT) ? (8'(burstOf(remaining_q)) - 8'd1) : 8'd0;

  assign bus.pixelValid = (count_q != '0);
  assign bus.pixelData  = !bus.pixelValid ? 16'd0 : (halfSel_q ? headWord[15:0] : headWord[31:16]);
  assign bus.frameEnd   = bus.pixelValid & halfSel_q & (outWords_q == 19'd1);

  // Next-state logic: FIFO bookkeeping first, then CI side effects, then the bus FSM (start overrides).
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    curAddr_d   = curAddr_q;
    wordCount_d = wordCount_q;
    remaining_d = remaining_q;
    done_d      = done_q;
    error_d     = error_q;
    wrPtr_d     = wrPtr_q + AW'(push);
    rdPtr_d     = rdPtr_q + AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    halfSel_d   = pixelXfer ? ~halfSel_q : halfSel_q;
    outWords_d  = outWords_q - 19'(pop);

    if (ciSel && !busy && ciOp == 3'd0) base_d = {bus.ciValueB[31:2], 2'b00};
    if (ciSel && !busy && ciOp == 3'd1) wordCount_d = bus.ciValueB[18:0];
    if (ciSel && ciOp == 3'd3) begin
      done_d  = 1'b0;
      error_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ciSel && ciOp == 3'd2 && bus.ciValueB[0] && wordCount_q != 19'd0) begin
          curAddr_d   = base_q;
          remaining_d = wordCount_q;
          outWords_d  = wordCount_q;
          state_d     = (freeSlots >= burstOf(wordCount_q)) ? REQUEST : WAIT;
        end
      end
      REQUEST: begin
        if (bus.busErrorIn)    state_d = ABORT;
        else if (bus.busGrant) state_d = INIT;
      end
      INIT: begin
        state_d = bus.busErrorIn ? ABORT : READ;
      end
      READ: begin
        if (bus.busErrorIn) begin
          state_d = ABORT;
        end else begin
          if (push) begin
            curAddr_d   = curAddr_q + 32'd4;
            remaining_d = remaining_q - 19'd1;
          end
          if (bus.endTransactionIn) state_d = (remaining_d != 19'd0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (freeSlots >= burstOf(remaining_q)) state_d = REQUEST;
      end
      DONE: begin
        if (count_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      ABORT: begin
        state_d    = IDLE;
        error_d    = 1'b1;
        wrPtr_d    = '0;
        rdPtr_d    = '0;
        count_d    = '0;
        halfSel_d  = 1'b0;
        outWords_d = 19'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      base_q      <= 32'd0;
      curAddr_q   <= 32'd0;
      wordCount_q <= 19'd0;
      remaining_q <= 19'd0;
      outWords_q  <= 19'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      halfSel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      curAddr_q   <= curAddr_d;
      wordCount_q <= wordCount_d;
      remaining_q <= remaining_d;
      outWords_q  <= outWords_d;
      done_q      <= done_d;
      error_q     <= error_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      halfSel_q   <= halfSel_d;
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push) mem_q[wrPtr_q] <= bus.addressDataIn;
  end

endmodule

// File: tb/tb_camera_frame_reader.sv
// Scoreboard bench for camera_frame_reader: expected pixels and bursts are queued by the stimulus,
// a bus-slave model answers bursts, and a monitor compares every transferred pixel.
module tb_camera_frame_reader;

  logic clock;
  logic reset;
  camera_frame_reader_if bus();

  camera_frame_reader #(.customInstructionId(8'd0), .fifoDepthLog2(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  logic [16:0] expPix[$];
  logic [39:0] expBegin[$];
  int errAtWord = -1;
  int beginCount = 0;
  int endCount = 0;
  logic readyLevel = 1'b0;
  bit toggleMode = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] val, output logic [31:0] result);
    @(posedge clock); #1;
    bus.ciStart = 1'b1; bus.ciCke = 1'b1; bus.ciN = 8'd0;
    bus.ciValueA = {29'd0, op}; bus.ciValueB = val;
    @(negedge clock);
    result = bus.ciResult;
    @(posedge clock); #1;
    bus.ciStart = 1'b0; bus.ciCke = 1'b0; bus.ciValueA = 32'd0; bus.ciValueB = 32'd0;
  endtask

  function automatic logic [31:0] wordAt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic pushFrame(input logic [31:0] base, input int words);
    logic [31:0] a;
    for (int i = 0; i < words; i++) begin
      a = base + 32'(4 * i);
      expPix.push_back({1'b0, a[15:0]});
      expPix.push_back({(i == words - 1), ~a[15:0]});
    end
  endtask

  task automatic waitDrain(input int budget);
    int c = 0;
    while ((expPix.size() != 0 || expBegin.size() != 0) && c < budget) begin
      @(posedge clock);
      c++;
    end
    if (expPix.size() != 0 || expBegin.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL drainTimeout: pixels left %0d bursts left %0d, required 0", expPix.size(), expBegin.size());
    end
    repeat (4) @(posedge clock);
  endtask

  // pixelReady driver: level or toggle every cycle, changed just after the clock edge.
  initial begin
    bus.pixelReady = 1'b0;
    forever begin
      @(posedge clock); #1;
      bus.pixelReady = toggleMode ? ~bus.pixelReady : readyLevel;
    end
  end

  // Monitor: compares transferred pixels against the scoreboard and checks hold while stalled.
  logic [15:0] heldData;
  bit heldValid = 1'b0;
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (heldValid && bus.pixelValid) checkOutput("hold", 64'(bus.pixelData), 64'(heldData));
        heldValid = bus.pixelValid && !bus.pixelReady;
        heldData  = bus.pixelData;
        if (bus.pixelValid && bus.pixelReady) begin
          if (expPix.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL pixExtra: got %0h expected no pixel", {bus.frameEnd, bus.pixelData});
          end else begin
            e = expPix.pop_front();
            checkOutput("pixel", 64'({bus.frameEnd, bus.pixelData}), 64'(e));
          end
        end
        if (bus.endTransactionOut) endCount++;
      end else begin
        heldValid = 1'b0;
      end
    end
  end

  // Bus slave model: grants immediately, checks each burst header, returns wordAt() data.
  initial begin
    logic [31:0] addr;
    logic [7:0] n;
    logic [39:0] eb;
    bit stop;
    bus.busGrant = 1'b0; bus.dataValidIn = 1'b0; bus.endTransactionIn = 1'b0;
    bus.busErrorIn = 1'b0; bus.addressDataIn = 32'd0;
    forever begin
      @(negedge clock);
      bus.busGrant = bus.requestBus & reset;
      if (reset && bus.beginTransactionOut) begin
        beginCount++;
        addr = bus.addressDataOut;
        n = bus.burstSizeOut;
        if (expBegin.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL beginExtra: got addr %0h burst %0d expected none", addr, n);
        end else begin
          eb = expBegin.pop_front();
          checkOutput("begin", 64'({addr, n, bus.readNotWriteOut, bus.byteEnablesOut}), 64'({eb, 1'b1, 4'hF}));
        end
        stop = 1'b0;
        for (int k = 0; k <= int'(n); k++) begin
          @(negedge clock);
          if (!reset) begin stop = 1'b1; break; end
          if (k == errAtWord) begin
            bus.dataValidIn = 1'b0;
            bus.busErrorIn = 1'b1;
            errAtWord = -1;
            stop = 1'b1;
            break;
          end
          bus.dataValidIn = 1'b1;
          bus.addressDataIn = wordAt(addr + 32'(4 * k));
        end
        @(negedge clock);
        bus.dataValidIn = 1'b0;
        bus.busErrorIn = 1'b0;
        if (!stop && reset) bus.endTransactionIn = 1'b1;
        @(negedge clock);
        bus.endTransactionIn = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r;
    int startCount;
    int c;
    bus.ciStart = 1'b0; bus.ciCke = 1'b0; bus.ciN = 8'd0; bus.ciValueA = 32'd0; bus.ciValueB = 32'd0;
    reset = 1'b0;
    repeat (3) @(posedge clock); #1;
    checkOutput("resetOut", 64'({bus.requestBus, bus.beginTransactionOut, bus.endTransactionOut,
                bus.addressDataOut, bus.pixelValid, bus.pixelData, bus.frameEnd}), 64'd0);
    reset = 1'b1;
    applyStimulus(3'd3, 32'd0, r); checkOutput("resetStatus", 64'(r), 64'd0);

    // Test 1: four-word frame, masked base address
    readyLevel = 1'b1;
    applyStimulus(3'd0, 32'h0000_1003, r);
    applyStimulus(3'd1, 32'd4, r);
    applyStimulus(3'd4, 32'd0, r); checkOutput("baseRead", 64'(r), 64'h1000);
    @(posedge clock); #1;
    bus.ciStart = 1'b1; bus.ciCke = 1'b1; bus.ciN = 8'd5; bus.ciValueA = 32'd4;
    @(negedge clock);
    checkOutput("otherId", 64'({bus.ciDone, bus.ciResult}), 64'd0);
    @(posedge clock); #1;
    bus.ciStart = 1'b0; bus.ciCke = 1'b0; bus.ciN = 8'd0; bus.ciValueA = 32'd0;
    expBegin.push_back({32'h1000, 8'd3});
    expPix.push_back({1'b0, 16'h1000}); expPix.push_back({1'b0, 16'hEFFF});
    expPix.push_back({1'b0, 16'h1004}); expPix.push_back({1'b0, 16'hEFFB});
    expPix.push_back({1'b0, 16'h1008}); expPix.push_back({1'b0, 16'hEFF7});
    expPix.push_back({1'b0, 16'h100C}); expPix.push_back({1'b1, 16'hEFF3});
    applyStimulus(3'd2, 32'd1, r);
    waitDrain(400);
    applyStimulus(3'd3, 32'd0, r); checkOutput("status1", 64'(r), 64'h2);

    // Test 2: 40 words with the consumer stalled, then released
    readyLevel = 1'b0;
    applyStimulus(3'd0, 32'h0000_8000, r);
    applyStimulus(3'd1, 32'd40, r);
    expBegin.push_back({32'h8000, 8'd15});
    expBegin.push_back({32'h8040, 8'd15});
    expBegin.push_back({32'h8080, 8'd7});
    pushFrame(32'h8000, 40);
    startCount = beginCount;
    applyStimulus(3'd2, 32'd1, r);
    repeat (80) @(posedge clock);
    checkOutput("stallBursts", 64'(beginCount - startCount), 64'd1);
    checkOutput("stallNoReq", 64'(bus.requestBus), 64'd0);
    applyStimulus(3'd3, 32'd0, r); checkOutput("statusBusy", 64'(r), 64'h1);
    readyLevel = 1'b1;
    waitDrain(3000);
    applyStimulus(3'd3, 32'd0, r); checkOutput("status2", 64'(r), 64'h2);

    // Test 3: consumer ready toggling every cycle
    toggleMode = 1'b1;
    applyStimulus(3'd0, 32'h0000_6000, r);
    applyStimulus(3'd1, 32'd6, r);
    expBegin.push_back({32'h6000, 8'd5});
    pushFrame(32'h6000, 6);
    applyStimulus(3'd2, 32'd1, r);
    waitDrain(600);
    toggleMode = 1'b0;
    readyLevel = 1'b0;
    applyStimulus(3'd3, 32'd0, r); checkOutput("status3", 64'(r), 64'h2);

    // Test 4: bus error on the second word of a burst
    endCount = 0;
    applyStimulus(3'd0, 32'h0000_2000, r);
    applyStimulus(3'd1, 32'd4, r);
    expBegin.push_back({32'h2000, 8'd3});
    errAtWord = 1;
    applyStimulus(3'd2, 32'd1, r);
    c = 0;
    while (endCount == 0 && c < 100) begin @(posedge clock); c++; end
    repeat (4) @(posedge clock);
    checkOutput("abortPulse", 64'(endCount), 64'd1);
    checkOutput("abortPixValid", 64'(bus.pixelValid), 64'd0);
    applyStimulus(3'd3, 32'd0, r); checkOutput("statusErr", 64'(r), 64'h4);
    applyStimulus(3'd3, 32'd0, r); checkOutput("statusCleared", 64'(r), 64'h0);

    // Test 5: base write ignored while busy; zero-length start ignored
    applyStimulus(3'd0, 32'h0000_3000, r);
    applyStimulus(3'd1, 32'd20, r);
    expBegin.push_back({32'h3000, 8'd15});
    expBegin.push_back({32'h3040, 8'd3});
    pushFrame(32'h3000, 20);
    applyStimulus(3'd2, 32'd1, r);
    repeat (10) @(posedge clock);
    applyStimulus(3'd0, 32'h0000_5000, r);
    applyStimulus(3'd4, 32'd0, r); checkOutput("baseBusy", 64'(r), 64'h3000);
    readyLevel = 1'b1;
    waitDrain(2000);
    applyStimulus(3'd3, 32'd0, r); checkOutput("status5", 64'(r), 64'h2);
    applyStimulus(3'd1, 32'd0, r);
    applyStimulus(3'd2, 32'd1, r);
    repeat (5) @(posedge clock);
    checkOutput("zeroNoReq", 64'(bus.requestBus), 64'd0);
    applyStimulus(3'd3, 32'd0, r); checkOutput("zeroStatus", 64'(r), 64'h0);

    // Test 6: reset asserted during a read burst
    readyLevel = 1'b0;
    endCount = 0;
    applyStimulus(3'd0, 32'h0000_4000, r);
    applyStimulus(3'd1, 32'd16, r);
    expBegin.push_back({32'h4000, 8'd15});
    startCount = beginCount;
    applyStimulus(3'd2, 32'd1, r);
    c = 0;
    while (beginCount == startCount && c < 100) begin @(negedge clock); c++; end
    checkOutput("burst6Started", 64'(beginCount - startCount), 64'd1);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("resetMidOut", 64'({bus.requestBus, bus.beginTransactionOut, bus.endTransactionOut,
                bus.addressDataOut, bus.pixelValid, bus.pixelData, bus.frameEnd}), 64'd0);
    repeat (2) @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    checkOutput("postResetPixValid", 64'(bus.pixelValid), 64'd0);
    checkOutput("noAbortOnReset", 64'(endCount), 64'd0);
    applyStimulus(3'd3, 32'd0, r); checkOutput("postResetStatus", 64'(r), 64'h0);
    applyStimulus(3'd4, 32'd0, r); checkOutput("postResetBase", 64'(r), 64'h0);
    repeat (5) @(posedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
